// File: rtl/fft_ctrl.sv
// Radix-2 DIT in-place FFT sequencer: butterfly addresses, twiddle index, write-back.
// Optional status outputs o_stage/o_stage_done under `define FFT_CTRL_STATUS_EN.
module fft_ctrl #(
  parameter int N        = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic                       i_stall,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_rd_en,
  output logic [$clog2(N)-1:0]       o_rd_addr_a,
  output logic [$clog2(N)-1:0]       o_rd_addr_b,
  output logic                       o_tw_rd_en,
  output logic [$clog2(N)-2:0]       o_tw_addr,
  output logic                       o_wr_en,
  output logic [$clog2(N)-1:0]       o_wr_addr_a,
  output logic [$clog2(N)-1:0]       o_wr_addr_b
`ifdef FFT_CTRL_STATUS_EN
  ,
  output logic [$clog2($clog2(N)):0] o_stage,
  output logic                       o_stage_done
`endif
);

  localparam int AW = $clog2(N);
  localparam int BW = AW - 1;
  localparam int SW = $clog2(AW) + 1;
  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int PW = 2 * AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [BW-1:0]   b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   rd_a_q, rd_a_d;
  logic [AW-1:0]   rd_b_q, rd_b_d;
  logic [BW-1:0]   tw_q, tw_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sdone_q, sdone_d;
  logic [PW-1:0]   pipe_q [PIPE_LAT];
  logic [PW-1:0]   pipe_d [PIPE_LAT];

  logic [AW-1:0]   half, pos, grp, a, twf;

  always_comb begin
    half = AW'(1) << s_q;
    pos  = {1'b0, b_q} & (half - AW'(1));
    grp  = {1'b0, b_q} >> s_q;
    a    = (grp << (s_q + SW'(1))) | pos;
    twf  = pos << (SW'(AW - 1) - s_q);
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    rd_en_d = 1'b0;
    rd_a_d  = rd_a_q;
    rd_b_d  = rd_b_q;
    tw_d    = tw_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sdone_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          s_d     = '0;
          b_d     = '0;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (!i_stall) begin
          rd_en_d = 1'b1;
          rd_a_d  = a;
          rd_b_d  = a + half;
          tw_d    = twf[BW-1:0];
          b_d     = b_q + BW'(1);
          if (b_q == '1) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end
      DRAIN: begin
        // Hold off the next stage until its inputs are written back.
        busy_d = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(PIPE_LAT - 1)) begin
          sdone_d = 1'b1;
          if (s_q == SW'(AW - 1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            s_d     = s_q + SW'(1);
            b_d     = '0;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pipe_d[0] = {rd_en_q, rd_a_q, rd_b_q};
    for (int i = 1; i < PIPE_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sdone_q <= 1'b0;
      pipe_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      tw_q    <= tw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sdone_q <= sdone_d;
      pipe_q  <= pipe_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_rd_en     = rd_en_q;
  assign o_tw_rd_en  = rd_en_q;
  assign o_rd_addr_a = rd_a_q;
  assign o_rd_addr_b = rd_b_q;
  assign o_tw_addr   = tw_q;
  assign {o_wr_en, o_wr_addr_a, o_wr_addr_b} = pipe_q[PIPE_LAT-1];

`ifdef FFT_CTRL_STATUS_EN
  assign o_stage      = s_q;
  assign o_stage_done = sdone_q;
`else
  logic unused_sdone;
  assign unused_sdone = sdone_q;
`endif

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl (N=8, PIPE_LAT=2); optional FFT_CTRL_STATUS_EN checks.
module tb_fft_ctrl;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic       i_stall;
  logic       o_busy, o_done, o_rd_en, o_tw_rd_en, o_wr_en;
  logic [2:0] o_rd_addr_a, o_rd_addr_b, o_wr_addr_a, o_wr_addr_b;
  logic [1:0] o_tw_addr;
`ifdef FFT_CTRL_STATUS_EN
  logic [2:0] o_stage;
  logic       o_stage_done;
`endif

  fft_ctrl #(.N(8), .PIPE_LAT(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_stall     (i_stall),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_rd_en     (o_rd_en),
    .o_rd_addr_a (o_rd_addr_a),
    .o_rd_addr_b (o_rd_addr_b),
    .o_tw_rd_en  (o_tw_rd_en),
    .o_tw_addr   (o_tw_addr),
    .o_wr_en     (o_wr_en),
    .o_wr_addr_a (o_wr_addr_a),
    .o_wr_addr_b (o_wr_addr_b)
`ifdef FFT_CTRL_STATUS_EN
    ,
    .o_stage     (o_stage),
    .o_stage_done(o_stage_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int ta [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int tb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int tt [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  int iss[12];

  int een[64];
  int ea [64];
  int eb [64];
  int et [64];
  int est[64];

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 16'(o_busy), 16'd0);
    chk({tag, "_done"}, 16'(o_done), 16'd0);
    chk({tag, "_rd_en"}, 16'(o_rd_en), 16'd0);
    chk({tag, "_tw_en"}, 16'(o_tw_rd_en), 16'd0);
    chk({tag, "_wr_en"}, 16'(o_wr_en), 16'd0);
    chk({tag, "_rd_addr"}, 16'({o_rd_addr_a, o_rd_addr_b}), 16'd0);
    chk({tag, "_wr_addr"}, 16'({o_wr_addr_a, o_wr_addr_b}), 16'd0);
    chk({tag, "_tw_addr"}, 16'(o_tw_addr), 16'd0);
  endtask

  // Runs one start: expected schedule comes from iss[] and the hand tables.
  task automatic run(input int done_c, input int st_lo, input int st_hi,
                     input bit pulse, input int stop_c);
    for (int c = 0; c < 64; c++) begin
      een[c] = 0; ea[c] = 0; eb[c] = 0; et[c] = 0; est[c] = 0;
    end
    for (int i = 0; i < 12; i++) begin
      een[iss[i]] = 1;
      ea[iss[i]]  = ta[i];
      eb[iss[i]]  = tb[i];
      et[iss[i]]  = tt[i];
      est[iss[i]] = i / 4;
    end
    for (int c = iss[0] + 1; c < 64; c++) begin
      if (een[c] == 0) begin
        ea[c] = ea[c-1]; eb[c] = eb[c-1]; et[c] = et[c-1];
      end
    end
    i_start = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    i_start = 1'b0;
    chk("c0_busy", 16'(o_busy), 16'd0);
    chk("c0_rd_en", 16'(o_rd_en), 16'd0);
    for (int c = 1; c <= stop_c; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      chk("rd_en", 16'(o_rd_en), 16'(een[c]));
      chk("tw_rd_en", 16'(o_tw_rd_en), 16'(een[c]));
      if (c >= iss[0] && c <= iss[11]) begin
        chk("rd_a", 16'(o_rd_addr_a), 16'(ea[c]));
        chk("rd_b", 16'(o_rd_addr_b), 16'(eb[c]));
        chk("tw_addr", 16'(o_tw_addr), 16'(et[c]));
      end
      chk("wr_en", 16'(o_wr_en), 16'(c >= 2 ? een[c-2] : 0));
      if (c >= 2 && een[c-2] != 0) begin
        chk("wr_a", 16'(o_wr_addr_a), 16'(ea[c-2]));
        chk("wr_b", 16'(o_wr_addr_b), 16'(eb[c-2]));
      end
      chk("busy", 16'(o_busy), 16'(c < done_c));
      chk("done", 16'(o_done), 16'(c == done_c));
`ifdef FFT_CTRL_STATUS_EN
      if (een[c] != 0) chk("stage", 16'(o_stage), 16'(est[c]));
      chk("stage_done", 16'(o_stage_done),
          16'(c == iss[3] + 2 || c == iss[7] + 2 || c == iss[11] + 2));
`endif
      i_stall = (c >= st_lo - 1 && c <= st_hi - 1 && st_lo > 0);
      i_start = pulse && (c == 4 || c == 11);
    end
    i_stall = 1'b0;
    i_start = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("idle");

    iss = '{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16};
    run(19, 0, 0, 1'b0, 20);

    iss = '{1, 4, 5, 6, 9, 10, 11, 12, 15, 16, 17, 18};
    run(21, 2, 3, 1'b0, 22);

    iss = '{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16};
    run(19, 0, 0, 1'b1, 20);

    run(19, 0, 0, 1'b0, 9);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst_done", 16'(o_done), 16'd0);
      chk("post_rst_busy", 16'(o_busy), 16'd0);
      chk("post_rst_wr", 16'(o_wr_en), 16'd0);
    end

    run(19, 0, 0, 1'b0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
